mips_ex_alu_pipe: RTL

Parametrised EX-stage integer execution unit for the MIPS pipeline. It performs all single-cycle ALU operations with a registered output and valid/ready handshakes. It also runs iterative MULT/MULTU/DIV/DIVU into private HI/LO registers, with MFHI/MFLO/MTHI/MTLO access. It sits between the ID/EX operand muxes and the EX/MEM register, and replaces the purely combinational ALU datapath.

---
 rtl/mips_alu_pkg.sv | 49 ++++
 rtl/mips_ex_alu_pipe_if.sv | 27 ++
 rtl/mips_alu_muldiv.sv | 158 +++++++++++++++
 rtl/mips_ex_alu_pipe.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - shared types and helpers for the EX-stage ALU pipe
// Purpose : operation encodings, iterative-engine FSM states and small helpers
//           used by mips_ex_alu_pipe and mips_alu_muldiv.
// Ports   : none (package).
package mips_alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_ADDU  = 5'd1,
    OP_SUB   = 5'd2,
    OP_SUBU  = 5'd3,
    OP_AND   = 5'd4,
    OP_OR    = 5'd5,
    OP_XOR   = 5'd6,
    OP_NOR   = 5'd7,
    OP_SLL   = 5'd8,
    OP_SRL   = 5'd9,
    OP_SRA   = 5'd10,
    OP_SLT   = 5'd11,
    OP_SLTU  = 5'd12,
    OP_LUI   = 5'd13,
    OP_MULT  = 5'd14,
    OP_MULTU = 5'd15,
    OP_DIV   = 5'd16,
    OP_DIVU  = 5'd17,
    OP_MFHI  = 5'd18,
    OP_MFLO  = 5'd19,
    OP_MTHI  = 5'd20,
    OP_MTLO  = 5'd21
  } mips_alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_HOLD = 3'd4
  } md_state_e;

  // Counter must hold DW-1; never narrower than one bit.
  function automatic int cnt_width(input int dw);
    return (dw > 2) ? $clog2(dw) : 1;
  endfunction

  function automatic logic is_iter_op(input mips_alu_op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mips_ex_alu_pipe_if.sv
// rtl/mips_ex_alu_pipe_if.sv - request/response handshake bundle of the ALU pipe
// Purpose : groups the request (op + operands) and response (result + overflow)
//           valid/ready channels.
// Ports   : master = issuing/consuming side, slave = execution unit.
interface mips_ex_alu_pipe_if #(
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_op;
  logic [DW-1:0] req_op1;
  logic [DW-1:0] req_op2;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_res;
  logic          rsp_ovf;

  modport master (
    output req_valid, req_op, req_op1, req_op2, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_ovf
  );

  modport slave (
    input  req_valid, req_op, req_op1, req_op2, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_ovf
  );
endinterface

// File: rtl/mips_alu_muldiv.sv
// rtl/mips_alu_muldiv.sv - iterative MULT/MULTU/DIV/DIVU engine with HI/LO
// Purpose : radix-2 shift-add multiply and restoring divide over DW iterations,
//           sign correction in FIX, private HI/LO registers with MTHI/MTLO writes.
// Ports   : clk, rst_n (async low), flush; start/op/op1/op2 launch an operation;
//           hi_we/lo_we write HI/LO from op1; rsp_ready lets FIX/HOLD retire;
//           idle, busy, done (high in FIX), lo_new (LO value written in FIX), hi, lo.
module mips_alu_muldiv
  import mips_alu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          start,
  input  mips_alu_op_e  op,
  input  logic [DW-1:0] op1,
  input  logic [DW-1:0] op2,
  input  logic          hi_we,
  input  logic          lo_we,
  input  logic          rsp_ready,
  output logic          idle,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] lo_new,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);
  localparam int CW = cnt_width(DW);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*DW-1:0] acc_q, acc_d;
  logic [DW-1:0]   opb_q, opb_d;
  logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic            neg_q, neg_d, rneg_q, rneg_d, div_q, div_d;

  // Operand preparation: signed ops run on magnitudes.
  logic          is_div, sgn, s1, s2;
  logic [DW-1:0] a_mag, b_mag;
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign sgn    = (op == OP_MULT) || (op == OP_DIV);
  assign s1     = sgn & op1[DW-1];
  assign s2     = sgn & op2[DW-1];
  assign a_mag  = s1 ? -op1 : op1;
  assign b_mag  = s2 ? -op2 : op2;

  // Multiply step: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
  logic [DW:0]     madd;
  logic [2*DW-1:0] mul_next;
  assign madd     = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opb_q} : {(DW+1){1'b0}});
  assign mul_next = {madd, acc_q[DW-1:1]};

  // Divide step: acc = {remainder, dividend/quotient}; trial-subtract shifted remainder.
  // A zero divisor always "fits", giving an all-ones quotient and remainder = dividend.
  logic [DW:0]     dtop;
  logic [DW-1:0]   dsub;
  logic            dge;
  logic [2*DW-1:0] div_next;
  assign dtop     = acc_q[2*DW-1:DW-1];
  assign dge      = dtop >= {1'b0, opb_q};
  assign dsub     = dtop[DW-1:0] - opb_q;
  assign div_next = dge ? {dsub, acc_q[DW-2:0], 1'b1} : {dtop[DW-1:0], acc_q[DW-2:0], 1'b0};

  // Sign correction applied in FIX.
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   q_raw, r_raw, hi_new;
  assign prod   = neg_q ? -acc_q : acc_q;
  assign q_raw  = acc_q[DW-1:0];
  assign r_raw  = acc_q[2*DW-1:DW];
  assign lo_new = div_q ? (neg_q ? -q_raw : q_raw) : prod[DW-1:0];
  assign hi_new = div_q ? (rneg_q ? -r_raw : r_raw) : prod[2*DW-1:DW];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div_d   = div_q;
    done    = 1'b0;

    if (hi_we) hi_d = op1;
    if (lo_we) lo_d = op1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = is_div ? ST_DIV : ST_MUL;
          cnt_d   = CW'(DW - 1);
          acc_d   = {{DW{1'b0}}, a_mag};
          opb_d   = b_mag;
          div_d   = is_div;
          // Divide-by-zero keeps the raw all-ones quotient.
          neg_d   = (s1 ^ s2) & (~is_div | (op2 != '0));
          rneg_d  = s1;
        end
      end
      ST_MUL, ST_DIV: begin
        acc_d = (state_q == ST_DIV) ? div_next : mul_next;
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_FIX: begin
        done    = 1'b1;
        hi_d    = hi_new;
        lo_d    = lo_new;
        state_d = rsp_ready ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // An aborted operation never reaches HI/LO.
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      done    = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div_q   <= div_d;
    end
  end

  assign idle = (state_q == ST_IDLE);
  assign busy = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/mips_ex_alu_pipe.sv
// rtl/mips_ex_alu_pipe.sv - EX-stage integer unit with registered result
// Purpose : single-cycle ALU ops with a registered response and valid/ready
//           handshakes; iterative mul/div and HI/LO handled by mips_alu_muldiv.
// Ports   : clk, rst_n (async low), flush (abort, highest priority);
//           bus (slave): req_valid/req_ready/req_op/req_op1/req_op2,
//           rsp_valid/rsp_ready/rsp_res/rsp_ovf; busy (iterative op running).
module mips_ex_alu_pipe
  import mips_alu_pkg::*;
#(
  parameter int DW  = 32,
  parameter int SHW = $clog2(DW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  mips_ex_alu_pipe_if.slave bus,
  output logic              busy
);
  mips_alu_op_e  op;
  logic [DW-1:0] op1, op2;
  assign op  = mips_alu_op_e'(bus.req_op);
  assign op1 = bus.req_op1;
  assign op2 = bus.req_op2;

  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_res_q, rsp_res_d;
  logic          rsp_ovf_q, rsp_ovf_d;

  logic          md_idle, md_done;
  logic [DW-1:0] md_lo_new, hi, lo;
  logic          accept, iter_op;

  assign bus.req_ready = md_idle & (~rsp_valid_q | bus.rsp_ready);
  assign accept        = bus.req_valid & bus.req_ready & ~flush;
  assign iter_op       = is_iter_op(op);

  function automatic logic [DW-1:0] bit_rev(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = x[DW-1-i];
    return r;
  endfunction

  // Single-cycle datapath.
  logic          sub, add_ovf, sh_right, sh_fill;
  logic [DW-1:0] b_eff, sum, sh_in, sh_l, sh_out, res;
  logic [SHW-1:0] amt;
  logic          ovf;

  always_comb begin
    sub      = (op == OP_SUB) || (op == OP_SUBU);
    b_eff    = sub ? ~op2 : op2;
    sum      = op1 + b_eff + {{(DW-1){1'b0}}, sub};
    add_ovf  = (op1[DW-1] == b_eff[DW-1]) && (sum[DW-1] != op1[DW-1]);

    // Right shifts reuse the left shifter on bit-reversed data; SRA fill enters
    // at the low end and lands at the top after reversing back.
    amt      = op2[SHW-1:0];
    sh_right = (op == OP_SRL) || (op == OP_SRA);
    sh_fill  = (op == OP_SRA) & op1[DW-1];
    sh_in    = sh_right ? bit_rev(op1) : op1;
    sh_l     = (sh_in << amt) | (sh_fill ? ~({DW{1'b1}} << amt) : {DW{1'b0}});
    sh_out   = sh_right ? bit_rev(sh_l) : sh_l;

    res = sum;
    ovf = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        res = sum;
        ovf = add_ovf;
      end
      OP_ADDU, OP_SUBU:          res = sum;
      OP_AND:                    res = op1 & op2;
      OP_OR:                     res = op1 | op2;
      OP_XOR:                    res = op1 ^ op2;
      OP_NOR:                    res = ~(op1 | op2);
      OP_SLL, OP_SRL, OP_SRA:    res = sh_out;
      OP_SLT:                    res = {{(DW-1){1'b0}}, $signed(op1) < $signed(op2)};
      OP_SLTU:                   res = {{(DW-1){1'b0}}, op1 < op2};
      OP_LUI:                    res = op2 << (DW / 2);
      OP_MFHI:                   res = hi;
      OP_MFLO:                   res = lo;
      OP_MTHI, OP_MTLO,
      OP_MULT, OP_MULTU,
      OP_DIV, OP_DIVU:           res = '0;
      default:                   res = sum;
    endcase
  end

  // Response register: flush > iterative completion > new single-cycle op > drain.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_res_d   = rsp_res_q;
    rsp_ovf_d   = rsp_ovf_q;
    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (md_done) begin
      rsp_valid_d = 1'b1;
      rsp_res_d   = md_lo_new;
      rsp_ovf_d   = 1'b0;
    end else if (accept && !iter_op) begin
      rsp_valid_d = 1'b1;
      rsp_res_d   = res;
      rsp_ovf_d   = ovf;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_ovf   = rsp_ovf_q;

  mips_alu_muldiv #(.DW(DW)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .start     (accept & iter_op),
    .op        (op),
    .op1       (op1),
    .op2       (op2),
    .hi_we     (accept & (op == OP_MTHI)),
    .lo_we     (accept & (op == OP_MTLO)),
    .rsp_ready (bus.rsp_ready),
    .idle      (md_idle),
    .busy      (busy),
    .done      (md_done),
    .lo_new    (md_lo_new),
    .hi        (hi),
    .lo        (lo)
  );

endmodule
